// File: rtl/dct_xpose_ctrl_if.sv
// Handshake bundle between the row-pass stage, the transpose controller and the column-pass stage.
// Master side drives samples in and accepts transposed samples out; slave side is the controller.
interface dct_xpose_ctrl_if #(
  parameter int unsigned DW = 12
);
  logic                 ena_in;
  logic signed [DW-1:0] d_in;
  logic                 rdy_out;
  logic                 ena_out;
  logic signed [DW-1:0] d_out;
  logic                 rdy_in;
  logic                 sob_out;

  modport master (
    output ena_in, d_in, rdy_in,
    input  rdy_out, ena_out, d_out, sob_out
  );

  modport slave (
    input  ena_in, d_in, rdy_in,
    output rdy_out, ena_out, d_out, sob_out
  );
endinterface

// File: rtl/dct_xpose_ctrl.sv
// Transpose buffer controller: row-major writes, column-major replay, bank sequencing and handshakes.
// Define DCT_XPOSE_DBLBUF_EN for two ping-pong banks; otherwise a single bank is used.
module dct_xpose_ctrl #(
  parameter int unsigned DW = 12,
  parameter int unsigned N  = 8
) (
  input  logic             clk,
  input  logic             rst,
  dct_xpose_ctrl_if.slave  bus
);

  localparam int unsigned LN = $clog2(N);
  localparam int unsigned AW = 2 * LN;
  localparam logic [AW-1:0] LastIdx = AW'(N * N - 1);
`ifdef DCT_XPOSE_DBLBUF_EN
  localparam int unsigned NB = 2;
`else
  localparam int unsigned NB = 1;
`endif
  localparam int unsigned MW = AW + $clog2(NB);

  typedef enum logic [1:0] {BkEmpty, BkFilling, BkFull, BkDraining} bank_st_e;

  bank_st_e             st_q [2];
  bank_st_e             st_d [2];
  logic                 wr_bank_q, wr_bank_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [AW-1:0]        w_q, k_q;
  logic                 rdy_q, rdy_d;

  logic signed [DW-1:0] mem [NB*N*N];
  logic signed [DW-1:0] rdata_q;
  logic                 rd_vld_q, rd_first_q;
  logic signed [DW-1:0] d_out_q;
  logic                 ena_q, sob_q;
`ifndef DCT_XPOSE_DBLBUF_EN
  logic                 rd_last_q, out_last_q;
`endif

  logic          adv, wr_fire, rd_avail, rd_issue, out_xfer;
  logic [MW-1:0] waddr, raddr;

  always_comb begin
    // Pipeline advances when the output register is empty or being consumed.
    adv      = !ena_q || bus.rdy_in;
    wr_fire  = bus.ena_in && rdy_q;
    rd_avail = (st_q[rd_bank_q] == BkFull) ||
               ((st_q[rd_bank_q] == BkDraining) && (k_q != '0));
    rd_issue = adv && rd_avail;
    out_xfer = ena_q && bus.rdy_in;
`ifdef DCT_XPOSE_DBLBUF_EN
    waddr = {wr_bank_q, w_q};
    raddr = {rd_bank_q, k_q[LN-1:0], k_q[AW-1:LN]};
`else
    waddr = w_q;
    raddr = {k_q[LN-1:0], k_q[AW-1:LN]};
`endif
  end

  always_comb begin
    for (int b = 0; b < 2; b++) st_d[b] = st_q[b];
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    if (wr_fire) begin
      if (w_q == LastIdx) begin
        st_d[wr_bank_q] = BkFull;
`ifdef DCT_XPOSE_DBLBUF_EN
        wr_bank_d = ~wr_bank_q;
`endif
      end else begin
        st_d[wr_bank_q] = BkFilling;
      end
    end
    if (rd_issue) begin
`ifdef DCT_XPOSE_DBLBUF_EN
      // Once the last read has left the RAM the bank may be refilled; this keeps ping-pong gapless.
      if (k_q == LastIdx) begin
        st_d[rd_bank_q] = BkEmpty;
        rd_bank_d = ~rd_bank_q;
      end else begin
        st_d[rd_bank_q] = BkDraining;
      end
`else
      st_d[rd_bank_q] = BkDraining;
`endif
    end
`ifndef DCT_XPOSE_DBLBUF_EN
    if (out_xfer && out_last_q) st_d[0] = BkEmpty;
`endif
    rdy_d = (st_d[wr_bank_d] == BkEmpty) || (st_d[wr_bank_d] == BkFilling);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) st_q[b] <= BkEmpty;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      w_q        <= '0;
      k_q        <= '0;
      rdy_q      <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_first_q <= 1'b0;
      d_out_q    <= '0;
      ena_q      <= 1'b0;
      sob_q      <= 1'b0;
`ifndef DCT_XPOSE_DBLBUF_EN
      rd_last_q  <= 1'b0;
      out_last_q <= 1'b0;
`endif
    end else begin
      for (int b = 0; b < 2; b++) st_q[b] <= st_d[b];
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      rdy_q     <= rdy_d;
      if (wr_fire)  w_q <= w_q + 1'b1;
      if (rd_issue) k_q <= k_q + 1'b1;
      if (adv) begin
        rd_vld_q   <= rd_issue;
        rd_first_q <= rd_issue && (k_q == '0);
        ena_q      <= rd_vld_q;
        sob_q      <= rd_vld_q && rd_first_q;
        if (rd_vld_q) d_out_q <= rdata_q;
`ifndef DCT_XPOSE_DBLBUF_EN
        rd_last_q  <= rd_issue && (k_q == LastIdx);
        out_last_q <= rd_vld_q && rd_last_q;
`endif
      end
    end
  end

  // Storage is plain synchronous RAM; stale contents are harmless because bank state gates reads.
  always_ff @(posedge clk) begin
    if (wr_fire)  mem[waddr] <= bus.d_in;
    if (rd_issue) rdata_q <= mem[raddr];
  end

  assign bus.rdy_out = rdy_q;
  assign bus.ena_out = ena_q;
  assign bus.d_out   = d_out_q;
  assign bus.sob_out = sob_q;

endmodule

// File: tb/tb_dct_xpose_ctrl.sv
// Scoreboard bench for dct_xpose_ctrl: driver pushes column-major expectations, monitor pops on
// every output transfer.
module tb_dct_xpose_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dct_xpose_ctrl_if #(.DW(12)) bus ();
  dct_xpose_ctrl #(.DW(12), .N(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic signed [11:0] d;
    logic               sob;
  } exp_t;

  exp_t               exp_q[$];
  int                 n_checks, n_fail;
  int                 cyc;
  logic signed [11:0] blk [64];
  bit                 stall_mode;
  int                 stall_waits;

  int out_cnt, out_sum, sob_cnt, rise_cnt, last_rise_edge, last_xfer_edge;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // rdy_in driver: 1,0,0,1 pattern while stall_mode, otherwise always ready.
  initial begin
    logic [3:0] pat;
    int ph;
    pat = 4'b1001;
    ph = 0;
    bus.rdy_in = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (stall_mode) begin
        bus.rdy_in = pat[ph];
        ph = (ph + 1) % 4;
      end else begin
        bus.rdy_in = 1'b1;
      end
    end
  end

  // Monitor / scoreboard checker.
  initial begin
    exp_t e;
    bit   hold_pend, ena_prev, prev_sob;
    int   prev_d;
    hold_pend = 0;
    ena_prev = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold_pend = 0;
        ena_prev = 0;
      end else begin
        if (hold_pend) begin
          chk("stall_hold_d_out", int'(bus.d_out), prev_d);
          chk("stall_hold_ena_out", int'(bus.ena_out), 1);
          chk("stall_hold_sob_out", int'(bus.sob_out), int'(prev_sob));
        end
        if (bus.ena_out && !ena_prev) begin
          rise_cnt++;
          last_rise_edge = cyc;
        end
        if (bus.ena_out && bus.rdy_in) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output_queue_size", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            chk("d_out", int'(bus.d_out), int'(e.d));
            chk("sob_out", int'(bus.sob_out), int'(e.sob));
          end
          out_cnt++;
          out_sum += int'(bus.d_out);
          if (bus.sob_out) sob_cnt++;
          last_xfer_edge = cyc + 1;
        end
        hold_pend = bus.ena_out && !bus.rdy_in;
        prev_d    = int'(bus.d_out);
        prev_sob  = bus.sob_out;
        ena_prev  = bus.ena_out;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion",
             n_checks);
    $fatal(1, "watchdog");
  end

  task automatic fill_lin(input int base, input int scale);
    for (int i = 0; i < 64; i++) blk[i] = 12'(base + scale * i);
  endtask

  // Streams cnt samples of blk; returns the edge that accepted the last one.
  task automatic send(input int cnt, input bit push, output int acc_edge);
    exp_t e;
    int   waits;
    acc_edge = -1;
    if (push) begin
      for (int c = 0; c < 8; c++) begin
        for (int r = 0; r < 8; r++) begin
          e.d   = blk[r*8 + c];
          e.sob = (r == 0) && (c == 0);
          exp_q.push_back(e);
        end
      end
    end
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk);
      bus.ena_in = 1'b1;
      bus.d_in   = blk[i];
      waits = 0;
      while (!bus.rdy_out) begin
        if (waits >= 300) begin
          chk("send_rdy_timeout", int'(bus.rdy_out), 1);
          bus.ena_in = 1'b0;
          return;
        end
        @(negedge clk);
        waits++;
        stall_waits++;
      end
      acc_edge = cyc + 1;
    end
    @(posedge clk);
    #1;
    bus.ena_in = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.ena_out) return;
    end
    chk("drain_timeout_pending", exp_q.size(), 0);
  endtask

  initial begin
    int t0, snap_out, snap_sob, snap_rise, snap_sum, snap_stall, lowcnt, rise_edge;
    bus.ena_in = 1'b0;
    bus.d_in   = '0;
    stall_mode = 0;
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("reset_rdy_out", int'(bus.rdy_out), 0);
    chk("reset_ena_out", int'(bus.ena_out), 0);
    chk("reset_sob_out", int'(bus.sob_out), 0);
    chk("reset_d_out", int'(bus.d_out), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rdy_out_after_reset", int'(bus.rdy_out), 1);

    // 1: one block, value r*8+c, checks order, sob and latency
    snap_out = out_cnt; snap_sob = sob_cnt;
    fill_lin(0, 1);
    send(64, 1, t0);
    wait_drain();
    chk("t1_latency", last_rise_edge - t0, 2);
    chk("t1_out_count", out_cnt - snap_out, 64);
    chk("t1_sob_count", sob_cnt - snap_sob, 1);

`ifdef DCT_XPOSE_DBLBUF_EN
    // 2: three back-to-back blocks through the ping-pong banks
    snap_out = out_cnt; snap_sob = sob_cnt; snap_rise = rise_cnt; snap_stall = stall_waits;
    fill_lin(0, 1);
    send(64, 1, t0);
    fill_lin(100, 1);
    send(64, 1, t0);
    fill_lin(200, 1);
    send(64, 1, t0);
    wait_drain();
    chk("t2_rdy_stalls", stall_waits - snap_stall, 0);
    chk("t2_out_count", out_cnt - snap_out, 192);
    chk("t2_contiguous_rises", rise_cnt - snap_rise, 1);
    chk("t2_sob_count", sob_cnt - snap_sob, 3);
`else
    // 3: single bank blocks the writer until the final output of the block transfers
    fill_lin(300, 1);
    send(64, 1, t0);
    lowcnt = 0;
    rise_edge = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.rdy_out) begin
        bus.ena_in = 1'b0;
        rise_edge = cyc;
        break;
      end
      bus.ena_in = 1'b1;
      bus.d_in   = -12'sd777;
      lowcnt++;
    end
    chk("t3_rdy_low_cycles", lowcnt, 66);
    chk("t3_rdy_rise_after_accept", rise_edge - t0, 66);
    chk("t3_rdy_rise_vs_last_xfer", rise_edge, last_xfer_edge);
    fill_lin(400, 1);
    send(64, 1, t0);
    wait_drain();
`endif

    // 4: rdy_in toggling 1,0,0,1 during drain; checksum of 3*i+5 over 64 samples is 6368
    snap_out = out_cnt; snap_sum = out_sum;
    stall_mode = 1;
    fill_lin(5, 3);
    send(64, 1, t0);
    wait_drain();
    stall_mode = 0;
    chk("t4_out_count", out_cnt - snap_out, 64);
    chk("t4_checksum", out_sum - snap_sum, 6368);

    // 5: extreme signed values in the corners
    fill_lin(-20, 1);
    blk[0]  = -12'sd2048;
    blk[63] = 12'sd2047;
    send(64, 1, t0);
    wait_drain();

    // 6: reset after 30 accepted samples, then a fresh block
    fill_lin(1500, 1);
    send(30, 0, t0);
    @(negedge clk);
    chk("t6_rdy_before_reset", int'(bus.rdy_out), 1);
    rst = 1'b0;
    #1;
    chk("t6_rdy_out_in_reset", int'(bus.rdy_out), 0);
    chk("t6_ena_out_in_reset", int'(bus.ena_out), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    snap_out = out_cnt;
    fill_lin(1000, -7);
    send(64, 1, t0);
    wait_drain();
    chk("t6_out_count", out_cnt - snap_out, 64);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
